// File: rtl/l1ca_code_nco_gen.sv
// GPS L1 C/A PRN code generator clocked by a half-chip code NCO.
// Emits early/prompt/late chips at half-chip spacing plus chip index and epoch strobe.

package l1ca_pkg;

  typedef logic [5:0]  sv_t;
  typedef logic [9:0]  gps_chip_t;
  typedef logic [10:1] l1ca_lfsr_t;

  typedef struct packed {
    logic [3:0] sa;
    logic [3:0] sb;
  } tap_pair_t;

  localparam gps_chip_t  LAST_CHIP = 10'd1022;
  localparam l1ca_lfsr_t LFSR_SEED = 10'h3FF;

  // G2 phase-select tap pair for each PRN; unused codes are masked by sv_valid.
  function automatic tap_pair_t phase_sel(input sv_t prn);
    tap_pair_t t;
    case (prn)
      6'd1:    t = '{sa: 4'd2, sb: 4'd6};
      6'd2:    t = '{sa: 4'd3, sb: 4'd7};
      6'd3:    t = '{sa: 4'd4, sb: 4'd8};
      6'd4:    t = '{sa: 4'd5, sb: 4'd9};
      6'd5:    t = '{sa: 4'd1, sb: 4'd9};
      6'd6:    t = '{sa: 4'd2, sb: 4'd10};
      6'd7:    t = '{sa: 4'd1, sb: 4'd8};
      6'd8:    t = '{sa: 4'd2, sb: 4'd9};
      6'd9:    t = '{sa: 4'd3, sb: 4'd10};
      6'd10:   t = '{sa: 4'd2, sb: 4'd3};
      6'd11:   t = '{sa: 4'd3, sb: 4'd4};
      6'd12:   t = '{sa: 4'd5, sb: 4'd6};
      6'd13:   t = '{sa: 4'd6, sb: 4'd7};
      6'd14:   t = '{sa: 4'd7, sb: 4'd8};
      6'd15:   t = '{sa: 4'd8, sb: 4'd9};
      6'd16:   t = '{sa: 4'd9, sb: 4'd10};
      6'd17:   t = '{sa: 4'd1, sb: 4'd4};
      6'd18:   t = '{sa: 4'd2, sb: 4'd5};
      6'd19:   t = '{sa: 4'd3, sb: 4'd6};
      6'd20:   t = '{sa: 4'd4, sb: 4'd7};
      6'd21:   t = '{sa: 4'd5, sb: 4'd8};
      6'd22:   t = '{sa: 4'd6, sb: 4'd9};
      6'd23:   t = '{sa: 4'd1, sb: 4'd3};
      6'd24:   t = '{sa: 4'd4, sb: 4'd6};
      6'd25:   t = '{sa: 4'd5, sb: 4'd7};
      6'd26:   t = '{sa: 4'd6, sb: 4'd8};
      6'd27:   t = '{sa: 4'd7, sb: 4'd9};
      6'd28:   t = '{sa: 4'd8, sb: 4'd10};
      6'd29:   t = '{sa: 4'd1, sb: 4'd6};
      6'd30:   t = '{sa: 4'd2, sb: 4'd7};
      6'd31:   t = '{sa: 4'd3, sb: 4'd8};
      6'd32:   t = '{sa: 4'd4, sb: 4'd9};
      default: t = '{sa: 4'd1, sb: 4'd1};
    endcase
    return t;
  endfunction

  function automatic l1ca_lfsr_t g1_step(input l1ca_lfsr_t g);
    return {g[9:1], g[3] ^ g[10]};
  endfunction

  function automatic l1ca_lfsr_t g2_step(input l1ca_lfsr_t g);
    return {g[9:1], g[2] ^ g[3] ^ g[6] ^ g[8] ^ g[9] ^ g[10]};
  endfunction

endpackage

module l1ca_code_nco_gen
  import l1ca_pkg::*;
#(
  parameter int NCO_W  = 32,
  parameter int MAX_SV = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             load,
  input  sv_t              sv,
  input  logic [NCO_W-1:0] code_rate,
  output logic             early,
  output logic             prompt,
  output logic             late,
  output gps_chip_t        chip_idx,
  output logic             half_tick,
  output logic             epoch,
  output logic             sv_valid
);

  localparam sv_t MAX_SV_V = sv_t'(MAX_SV);

  l1ca_lfsr_t       g1_q, g1_d;
  l1ca_lfsr_t       g2_q, g2_d;
  logic [NCO_W-1:0] nco_q, nco_d;
  logic             half_ph_q, half_ph_d;
  gps_chip_t        chip_q, chip_d;
  logic             prompt_q, prompt_d;
  logic             late_q, late_d;
  logic             half_tick_q, half_tick_d;
  logic             epoch_q, epoch_d;
  sv_t              sv_q, sv_d;

  logic [NCO_W:0]   nco_sum;
  logic             carry;
  tap_pair_t        taps;

  assign sv_valid = (sv_q != '0) && (sv_q <= MAX_SV_V);
  assign taps     = phase_sel(sv_q);
  assign early    = sv_valid & (g1_q[10] ^ g2_q[taps.sa] ^ g2_q[taps.sb]);

  assign nco_sum  = {1'b0, nco_q} + {1'b0, code_rate};
  assign carry    = nco_sum[NCO_W];

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    g1_d        = g1_q;
    g2_d        = g2_q;
    nco_d       = nco_q;
    half_ph_d   = half_ph_q;
    chip_d      = chip_q;
    prompt_d    = prompt_q;
    late_d      = late_q;
    sv_d        = sv_q;
    half_tick_d = 1'b0;
    epoch_d     = 1'b0;

    if (load) begin
      sv_d      = sv;
      g1_d      = LFSR_SEED;
      g2_d      = LFSR_SEED;
      nco_d     = '0;
      half_ph_d = 1'b0;
      chip_d    = '0;
      prompt_d  = 1'b0;
      late_d    = 1'b0;
    end else if (en) begin
      nco_d       = nco_sum[NCO_W-1:0];
      half_tick_d = carry;
      if (carry) begin
        // Taps shift on the pre-advance early value, giving half-chip spacing.
        late_d    = prompt_q;
        prompt_d  = early;
        half_ph_d = ~half_ph_q;
        if (half_ph_q) begin
          if (chip_q == LAST_CHIP) begin
            chip_d  = '0;
            g1_d    = LFSR_SEED;
            g2_d    = LFSR_SEED;
            epoch_d = 1'b1;
          end else begin
            chip_d  = chip_q + 10'd1;
            g1_d    = g1_step(g1_q);
            g2_d    = g2_step(g2_q);
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments and a reset sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      g1_q        <= LFSR_SEED;
      g2_q        <= LFSR_SEED;
      nco_q       <= '0;
      half_ph_q   <= 1'b0;
      chip_q      <= '0;
      prompt_q    <= 1'b0;
      late_q      <= 1'b0;
      half_tick_q <= 1'b0;
      epoch_q     <= 1'b0;
      sv_q        <= '0;
    end else begin
      g1_q        <= g1_d;
      g2_q        <= g2_d;
      nco_q       <= nco_d;
      half_ph_q   <= half_ph_d;
      chip_q      <= chip_d;
      prompt_q    <= prompt_d;
      late_q      <= late_d;
      half_tick_q <= half_tick_d;
      epoch_q     <= epoch_d;
      sv_q        <= sv_d;
    end
  end

  assign prompt    = prompt_q;
  assign late      = late_q;
  assign chip_idx  = chip_q;
  assign half_tick = half_tick_q;
  assign epoch     = epoch_q;

endmodule

// File: tb/tb_l1ca_code_nco_gen.sv
// Bench for l1ca_code_nco_gen: directed scenarios plus random control, all checked
// every cycle against a sequence-level model of the C/A code and carry count.

module tb_l1ca_code_nco_gen;

  localparam logic [31:0] HALF    = 32'h8000_0000;
  localparam logic [31:0] QUARTER = 32'h4000_0000;
  localparam longint      TWO32   = 64'sd4294967296;

  logic        clk = 1'b0;
  logic        nrst, en, load;
  logic [5:0]  sv;
  logic [31:0] code_rate;
  logic        early, prompt, late, half_tick, epoch, sv_valid;
  logic [9:0]  chip_idx;

  always #5 clk = ~clk;

  l1ca_code_nco_gen #(.NCO_W(32), .MAX_SV(32)) dut (
    .clk(clk), .nrst(nrst), .en(en), .load(load), .sv(sv), .code_rate(code_rate),
    .early(early), .prompt(prompt), .late(late), .chip_idx(chip_idx),
    .half_tick(half_tick), .epoch(epoch), .sv_valid(sv_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference sequences: G1/G2 outputs from their linear recurrences, PRN by tap offsets.
  bit g1s [0:1022];
  bit g2s [0:1022];
  int tap_a [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int tap_b [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  function automatic logic ca_chip(input int prn, input int c);
    return g1s[c] ^ g2s[(c + 10 - tap_a[prn]) % 1023] ^ g2s[(c + 10 - tap_b[prn]) % 1023];
  endfunction

  function automatic logic [9:0] first10(input int prn);
    logic [9:0] v = '0;
    for (int i = 0; i < 10; i++) v = {v[8:0], ca_chip(prn, i)};
    return v;
  endfunction

  // Model state: latched SV, NCO value and number of carries since load.
  int     m_sv;
  int     m_k;
  longint m_nco;
  logic   m_ht, m_ep, m_on = 1'b0;

  always @(posedge clk) begin
    longint sum;
    logic   valid;
    if (nrst === 1'b0) begin
      m_sv = 0; m_k = 0; m_nco = 0; m_ht = 0; m_ep = 0; m_on = 1'b1;
    end else if (load === 1'b1) begin
      m_sv = int'(sv); m_k = 0; m_nco = 0; m_ht = 0; m_ep = 0;
    end else if (en === 1'b1) begin
      sum  = m_nco + longint'(code_rate);
      m_ht = (sum >= TWO32);
      if (m_ht) begin
        sum -= TWO32;
        m_k++;
      end
      m_nco = sum;
      m_ep  = m_ht && (m_k % 2046 == 0);
    end else begin
      m_ht = 0; m_ep = 0;
    end
    #1;
    if (m_on) begin
      valid = (m_sv >= 1 && m_sv <= 32);
      check("chip_idx", chip_idx, (m_k / 2) % 1023);
      check("early", early, valid ? ca_chip(m_sv, (m_k / 2) % 1023) : 1'b0);
      check("prompt", prompt, (valid && m_k >= 1) ? ca_chip(m_sv, ((m_k - 1) / 2) % 1023) : 1'b0);
      check("late", late, (valid && m_k >= 2) ? ca_chip(m_sv, ((m_k - 2) / 2) % 1023) : 1'b0);
      check("half_tick", half_tick, m_ht);
      check("epoch", epoch, m_ep);
      check("sv_valid", sv_valid, valid);
    end
  end

  int   ep_count, cyc_count;
  logic any_out;

  task automatic drive(input logic rn, input logic e, input logic l,
                       input logic [5:0] s, input logic [31:0] r);
    nrst = rn; en = e; load = l; sv = s; code_rate = r;
    @(negedge clk);
    cyc_count++;
    if (epoch === 1'b1) ep_count++;
    any_out = any_out | early | prompt | late;
  endtask

  task automatic run(input int n);
    repeat (n) drive(1'b1, 1'b1, 1'b0, sv, code_rate);
  endtask

  task automatic load_sv(input logic [5:0] s, input logic [31:0] r);
    drive(1'b1, 1'b1, 1'b1, s, r);
    cyc_count = 0; ep_count = 0; any_out = 1'b0;
  endtask

  task automatic wait_epochs(input int target, input int limit);
    while (ep_count < target && cyc_count < limit) run(1);
  endtask

  task automatic wait_chip(input int c, input int limit);
    int k = 0;
    while (int'(chip_idx) != c && k < limit) begin
      run(1);
      k++;
    end
    check("reach_chip", chip_idx, c);
  endtask

  task automatic capture10(output logic [9:0] b);
    b = '0;
    for (int i = 0; i < 10; i++) begin
      b = {b[8:0], early};
      run(4);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    int         hts;

    for (int n = 0; n < 1023; n++) begin
      if (n < 10) begin
        g1s[n] = 1'b1;
        g2s[n] = 1'b1;
      end else begin
        g1s[n] = g1s[n-3] ^ g1s[n-10];
        g2s[n] = g2s[n-2] ^ g2s[n-3] ^ g2s[n-6] ^ g2s[n-8] ^ g2s[n-9] ^ g2s[n-10];
      end
    end
    check("model_prn1", first10(1), 10'b1100100000);
    check("model_prn2", first10(2), 10'b1110010000);
    check("model_prn3", first10(3), 10'b1111001000);

    nrst = 1'b0; en = 1'b0; load = 1'b0; sv = '0; code_rate = '0;
    cyc_count = 0; ep_count = 0; any_out = 1'b0;
    @(negedge clk);
    check("rst_out", {early, prompt, late, half_tick, epoch, sv_valid}, 6'b0);
    check("rst_chip", chip_idx, 0);

    // PRN1 and PRN2 openings at one half_tick per two cycles.
    load_sv(6'd1, HALF);
    check("load_chip0", chip_idx, 0);
    capture10(bits);
    check("prn1_first10", bits, 10'b1100100000);
    check("prn1_chip_after40", chip_idx, 10);
    load_sv(6'd2, HALF);
    capture10(bits);
    check("prn2_first10", bits, 10'b1110010000);

    // Full code period: epochs at 4092 and 8184 enabled cycles.
    load_sv(6'd1, HALF);
    wait_epochs(1, 5000);
    check("epoch1_cycle", cyc_count, 4092);
    check("epoch1_chip", chip_idx, 0);
    capture10(bits);
    check("prn1_repeat10", bits, 10'b1100100000);
    wait_epochs(2, 9000);
    check("epoch2_cycle", cyc_count, 8184);
    check("epoch_count", ep_count, 2);

    // E/P/L at quarter-rate: late must stay zero until the second half_tick.
    load_sv(6'd5, QUARTER);
    hts = 0;
    for (int i = 0; i < 40 && hts < 2; i++) begin
      run(1);
      if (half_tick === 1'b1) hts++;
      if (hts < 2) check("late_fill", late, 1'b0);
    end
    check("epl_halfticks", hts, 2);
    run(400);

    // Mid-run freeze, load collision with en, and reset.
    load_sv(6'd1, HALF);
    wait_chip(300, 1400);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, sv, code_rate);
      check("freeze_chip", chip_idx, 300);
      check("freeze_tick", half_tick, 1'b0);
    end
    wait_chip(500, 900);
    drive(1'b1, 1'b1, 1'b1, 6'd3, HALF);
    check("reload_chip", chip_idx, 0);
    capture10(bits);
    check("prn3_first10", bits, 10'b1111001000);
    run(33);
    drive(1'b0, 1'b1, 1'b0, sv, HALF);
    check("midrst_out", {early, prompt, late, half_tick, epoch, sv_valid}, 6'b0);
    check("midrst_chip", chip_idx, 0);

    // Invalid SVs: silent chips, running timebase.
    load_sv(6'd0, HALF);
    wait_epochs(1, 5000);
    check("sv0_epoch_cycle", cyc_count, 4092);
    check("sv0_silent", any_out, 1'b0);
    check("sv0_valid", sv_valid, 1'b0);
    load_sv(6'd33, HALF);
    run(500);
    check("sv33_silent", any_out, 1'b0);
    check("sv33_valid", sv_valid, 1'b0);

    // Random control traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      case ($urandom_range(0, 4))
        0:       r = $urandom;
        1:       r = 32'h0;
        2:       r = HALF;
        3:       r = 32'hFFFF_FFFF;
        default: r = $urandom_range(32'h1000_0000, 32'hF000_0000);
      endcase
      drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 99) == 0), 6'($urandom_range(0, 40)), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
